// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store sequencer:
// RV32I width codes, controller state encoding and request-decode helpers.
package dmem_pkg;

  localparam int XLEN = 32;

  // RV32I funct3 width/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  // Stores only have signed-less B/H/W codes; loads add BU/HU.
  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Halfword needs addr[0]=0, word needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return |off;
      default:     return 1'b0;
    endcase
  endfunction

  // Byte offset with the bits a misaligned access would violate forced to zero.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return {off[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return off;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte/halfword lane logic: extracts and extends load data
// from a memory word, and merges store data into an old word for RMW.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_load_data,
  output logic [XLEN-1:0] o_merged
);

  logic [4:0]  w_bit;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bit  = {i_off, 3'b000};
  assign w_byte = i_word[w_bit +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  // Load path: pick the addressed lane and sign- or zero-extend it
  always_comb begin
    // NOTE: assign a default before the case so no path leaves the output unassigned (which would infer a latch).
    o_load_data = i_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'b0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'b0, w_half};
      default: o_load_data = i_word;
    endcase
  end

  // Store path: replace only the addressed lane(s) of the old word
  always_comb begin
    o_merged = i_word;
    case (i_funct3[1:0])
      2'b00: o_merged[w_bit +: 8] = i_wdata[7:0];
      2'b01: begin
        if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
        else          o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a word-organised data
// memory. Loads and SW complete in one cycle; SB/SH use a two-cycle
// read-modify-write with a one-cycle stall on req_ready.
// Optional: define DMEM_MISALIGN_TRAP_EN to reject misaligned H/W accesses
// with rsp_err; otherwise misaligned accesses are silently aligned down.
module dmem_lsu_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  state_t          r_state;
  state_t          w_next_state;

  logic [AW-1:0]   r_idx;
  logic [1:0]      r_off;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_wdata;

  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_err;

  logic            w_accept;
  logic            w_misal;
  logic            w_err;
  logic [AW-1:0]   w_req_idx;
  logic [1:0]      w_req_off;
  logic [1:0]      w_lane_off;
  logic [2:0]      w_lane_f3;
  logic [XLEN-1:0] w_lane_wdata;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_merged;
  logic            w_unused_addr_hi;

  // Address bits above the word index wrap and are deliberately ignored.
  assign w_unused_addr_hi = ^req_addr[31:AW+2];
  assign w_req_idx        = req_addr[AW+1:2];
  assign w_req_off        = align_off(req_funct3, req_addr[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misal = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_misal = 1'b0;
`endif

  assign w_err = !is_legal(req_we, req_funct3) || w_misal;

  dmem_lane_unit u_lane (
    .i_word      (mem_rdata),
    .i_wdata     (w_lane_wdata),
    .i_off       (w_lane_off),
    .i_funct3    (w_lane_f3),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // Next state and memory/handshake outputs, all combinational from state
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    req_ready    = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = w_req_idx;
    mem_wdata    = req_wdata;
    w_lane_off   = w_req_off;
    w_lane_f3    = req_funct3;
    w_lane_wdata = req_wdata;
    case (r_state)
      IDLE: begin
        req_ready = !rst;
        w_accept  = req_valid && !rst;
        if (w_accept && !w_err && req_we) begin
          if (req_funct3 == F3_W) mem_we = 1'b1;
          else                    w_next_state = RMW;
        end
      end
      RMW: begin
        // Old word is re-read from the latched index; nothing wrote it since accept.
        mem_addr     = r_idx;
        mem_we       = !rst;
        mem_wdata    = w_merged;
        w_lane_off   = r_off;
        w_lane_f3    = r_funct3;
        w_lane_wdata = r_wdata;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Capture the request on the accept edge for the RMW cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_off    <= '0;
      r_funct3 <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_idx    <= w_req_idx;
      r_off    <= w_req_off;
      r_funct3 <= req_funct3;
      r_wdata  <= req_wdata;
    end
  end

  // Registered one-cycle response pulse with extended load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      if (r_state == RMW) begin
        r_rsp_valid <= 1'b1;
      end else if (w_accept) begin
        if (w_err) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
        end else if (!req_we) begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_load_data;
        end else if (req_funct3 == F3_W) begin
          r_rsp_valid <= 1'b1;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed vector table, hand-written
// back-to-back and reset-during-RMW sequences, then randomized traffic
// compared against a byte-lane reference model of the memory.
module tb_dmem_lsu_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: combinational read, synchronous write, plus a preload port
  logic [31:0]   tb_mem [DEPTH];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_idx = '0;
  logic [31:0]   pre_val = '0;
  int            we_cnt = 0;
  int            stall_cnt = 0;

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we)      tb_mem[mem_addr] <= mem_wdata;
    else if (pre_en) tb_mem[pre_idx]  <= pre_val;
    if (mem_we)                we_cnt    <= we_cnt + 1;
    if (!rst && !req_ready)    stall_cnt <= stall_cnt + 1;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = AW'(idx);
    pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Issue one request, wait for acceptance, then for the response pulse.
  // lat = edges from the accept edge (counted as 1) to the first rsp_valid.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rdata,
                         output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
    guard = 0;
    while (!req_ready && guard < 16) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 16) check("accept timeout req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Inputs need not be held after acceptance: scramble them.
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  // Reference model: byte-lane view of memory using plain arithmetic.
  logic [31:0] ref_mem [DEPTH];

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdata,
                       output logic err, output int lat);
    int          size, widx, sh;
    logic [31:0] base, mask, v;
    bit          legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    rdata = '0;
    err   = 1'b0;
    lat   = 1;
    if (!legal || (TRAP && (addr % size) != 0)) begin
      err = 1'b1;
      return;
    end
    base = addr - (addr % size);
    widx = int'((base / 4) % DEPTH);
    sh   = 8 * int'(base % 4);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
    if (!we) begin
      v = (ref_mem[widx] >> sh) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      rdata = v;
    end else begin
      ref_mem[widx] = (ref_mem[widx] & ~(mask << sh)) | ((wd & mask) << sh);
      if (size < 4) lat = 2;
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_word;
    int          exp_we;
    int          exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] pre,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input logic [31:0] exp_word, input int exp_we, input int exp_stall);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.pre = pre;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_word = exp_word; v.exp_we = exp_we; v.exp_stall = exp_stall;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lt, exp_lt, w0, s0, idx;

    // Reset: drive an SW during reset to show no write can escape
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h0000_0040;
    req_wdata  = 32'h1234_5678;
    #3;
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post-reset req_ready", 32'(req_ready), 32'd1);

    // Directed vector table
    //      we    f3     addr           wdata          pre            exp_rdata      err   lat word           we stall
    add_vec(1'b0, F3_W,  32'h0000_002C, 32'h0,         32'h0000_0008, 32'h0000_0008, 1'b0, 1, 32'h0000_0008, 0, 0);
    add_vec(1'b0, F3_B,  32'h0000_0071, 32'h0,         32'h8000_FF0A, 32'hFFFF_FFFF, 1'b0, 1, 32'h8000_FF0A, 0, 0);
    add_vec(1'b0, F3_BU, 32'h0000_0071, 32'h0,         32'h8000_FF0A, 32'h0000_00FF, 1'b0, 1, 32'h8000_FF0A, 0, 0);
    add_vec(1'b0, F3_H,  32'h0000_0072, 32'h0,         32'h8000_FF0A, 32'hFFFF_8000, 1'b0, 1, 32'h8000_FF0A, 0, 0);
    add_vec(1'b0, F3_HU, 32'h0000_0072, 32'h0,         32'h8000_FF0A, 32'h0000_8000, 1'b0, 1, 32'h8000_FF0A, 0, 0);
    add_vec(1'b0, F3_B,  32'h0000_0070, 32'h0,         32'h8000_FF0A, 32'h0000_000A, 1'b0, 1, 32'h8000_FF0A, 0, 0);
    add_vec(1'b1, F3_B,  32'h0000_0072, 32'h1234_5699, 32'h1122_3344, 32'h0,         1'b0, 2, 32'h1199_3344, 1, 1);
    add_vec(1'b1, F3_H,  32'h0000_0052, 32'h1234_BEEF, 32'hAABB_CCDD, 32'h0,         1'b0, 2, 32'hBEEF_CCDD, 1, 1);
    add_vec(1'b1, F3_B,  32'h0000_0013, 32'h5555_55AB, 32'h0000_0000, 32'h0,         1'b0, 2, 32'hAB00_0000, 1, 1);
    add_vec(1'b0, F3_HU, 32'h0000_0006, 32'h0,         32'h8765_4321, 32'h0000_8765, 1'b0, 1, 32'h8765_4321, 0, 0);
    add_vec(1'b1, F3_W,  32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0,         1'b0, 1, 32'hDEAD_BEEF, 1, 0);
    add_vec(1'b0, 3'b111,32'h0000_0040, 32'h0,         32'h1234_5678, 32'h0,         1'b1, 1, 32'h1234_5678, 0, 0);
    add_vec(1'b1, 3'b100,32'h0000_0044, 32'hFFFF_FFFF, 32'h0000_0055, 32'h0,         1'b1, 1, 32'h0000_0055, 0, 0);
    add_vec(1'b0, F3_W,  32'hFFFF_F02C, 32'h0,         32'h1357_2468, 32'h1357_2468, 1'b0, 1, 32'h1357_2468, 0, 0);
    add_vec(1'b0, F3_H,  32'h0000_0003, 32'h0,         32'hA5B6_C7D8,
            TRAP ? 32'h0 : 32'hFFFF_A5B6, TRAP, 1, 32'hA5B6_C7D8, 0, 0);
    add_vec(1'b1, F3_W,  32'h0000_004A, 32'hCAFE_F00D, 32'h0102_0304, 32'h0,         TRAP, 1,
            TRAP ? 32'h0102_0304 : 32'hCAFE_F00D, TRAP ? 0 : 1, 0);

    foreach (vecs[i]) begin
      idx = int'(vecs[i].addr[11:2]);
      preload(idx, vecs[i].pre);
      w0 = we_cnt;
      s0 = stall_cnt;
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lt);
      check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("v%0d latency", i), 32'(lt), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d mem word", i), tb_mem[idx], vecs[i].exp_word);
      check($sformatf("v%0d write count", i), 32'(we_cnt - w0), 32'(vecs[i].exp_we));
      check($sformatf("v%0d stall cycles", i), 32'(stall_cnt - s0), 32'(vecs[i].exp_stall));
    end

    // Back-to-back: SW then LW to the same word, accepted in the response cycle
    preload(16, 32'h0);
    run_req(1'b1, F3_W, 32'h0000_0040, 32'hDEAD_BEEF, rd, er, lt);
    check("b2b sw latency", 32'(lt), 32'd1);
    run_req(1'b0, F3_W, 32'h0000_0040, 32'h0, rd, er, lt);
    check("b2b lw latency", 32'(lt), 32'd1);
    check("b2b lw rdata", rd, 32'hDEAD_BEEF);
    // SB followed immediately by LW on the same word
    preload(20, 32'h1122_3344);
    run_req(1'b1, F3_B, 32'h0000_0051, 32'h0000_0077, rd, er, lt);
    check("b2b sb latency", 32'(lt), 32'd2);
    run_req(1'b0, F3_W, 32'h0000_0050, 32'h0, rd, er, lt);
    check("b2b lw after sb", rd, 32'h1122_7744);

    // Reset asserted during the RMW cycle
    preload(5, 32'hCAFE_1234);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h0000_0014;
    req_wdata  = 32'h0000_00EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rmw mem_we", 32'(mem_we), 32'd1);
    check("rmw req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rst mid-rmw mem_we", 32'(mem_we), 32'd0);
    check("rst mid-rmw rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rst mid-rmw word kept", tb_mem[5], 32'hCAFE_1234);
    check("rst mid-rmw no rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("after rst idle ready", 32'(req_ready), 32'd1);
    run_req(1'b0, F3_W, 32'h0000_0014, 32'h0, rd, er, lt);
    check("after rst word readback", rd, 32'hCAFE_1234);

    // Randomized traffic against the reference model (words 0..31, high bits wrap)
    for (int w = 0; w < 32; w++) begin
      ref_mem[w] = $urandom;
      preload(w, ref_mem[w]);
    end
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wd;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom & 32'hFFFF_F07F;
      wd   = $urandom;
      model(we, f3, addr, wd, exp_rd, exp_er, exp_lt);
      run_req(we, f3, addr, wd, rd, er, lt);
      check($sformatf("rand%0d rdata we=%0d f3=%0d a=%08h", n, we, f3, addr), rd, exp_rd);
      check($sformatf("rand%0d err", n), 32'(er), 32'(exp_er));
      check($sformatf("rand%0d latency", n), 32'(lt), 32'(exp_lt));
    end
    for (int w = 0; w < 32; w++)
      check($sformatf("final word %0d", w), tb_mem[w], ref_mem[w]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
